// File: rtl/pwm_duty_meter_if.sv
// Signal bundle between the PWM duty meter and its user: the measured input
// plus all result/status outputs. The meter attaches as slave.
interface pwm_duty_meter_if;
  logic       pwm_in;
  logic [3:0] duty;
  logic       duty_valid;
  logic [7:0] period;
  logic       stuck;
  logic       busy;
  logic       dropped;

  modport master (
    output pwm_in,
    input  duty, duty_valid, period, stuck, busy, dropped
  );

  modport slave (
    input  pwm_in,
    output duty, duty_valid, period, stuck, busy, dropped
  );
endinterface

// File: rtl/pwm_duty_meter.sv
// PWM duty meter: measures the period and high time between consecutive
// rising edges of an asynchronous PWM input and reports the duty cycle in
// tenths (0..10), computed by repeated addition, one step per cycle.
module pwm_duty_meter (
  input logic             clk,
  input logic             rst_n,
  pwm_duty_meter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StMeasure, StCalc, StDone} state_e;

  state_e      state_q, state_d;
  logic        s1, s2, s3;
  logic        level, rise, timeout;
  logic [7:0]  pcnt, hcnt;
  logic [7:0]  p_q, p_d;
  logic [11:0] target_q, target_d;
  logic [11:0] acc_q, acc_d;
  logic [11:0] acc_sum;
  logic [3:0]  k_q, k_d;
  logic [3:0]  duty_q, duty_d;
  logic [7:0]  period_q, period_d;
  logic        stuck_q, stuck_d;
  logic        valid_q, valid_d;
  logic        dropped_q, dropped_d;

  assign level   = s2;
  assign rise    = s2 & ~s3;
  assign acc_sum = acc_q + {4'd0, p_q};

  // Fires on the edge where pcnt steps 254 -> 255; a coincident rise wins.
  // IDLE is excluded so an unarmed block never reports a timeout.
  assign timeout = (state_q != StIdle) && !stuck_q && !rise && (pcnt == 8'd254);

  // Input synchroniser, edge history and period/high-time counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      s3   <= 1'b0;
      pcnt <= 8'd0;
      hcnt <= 8'd0;
    end else begin
      s1 <= bus.pwm_in;
      s2 <= s1;
      s3 <= s2;
      if (rise) begin
        pcnt <= 8'd1;
        hcnt <= 8'd1;
      end else begin
        if (pcnt != 8'd255) pcnt <= pcnt + 8'd1;
        if (level && (hcnt != 8'd255)) hcnt <= hcnt + 8'd1;
      end
    end
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      p_q       <= 8'd0;
      target_q  <= 12'd0;
      acc_q     <= 12'd0;
      k_q       <= 4'd0;
      duty_q    <= 4'd0;
      period_q  <= 8'd0;
      stuck_q   <= 1'b0;
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      target_q  <= target_d;
      acc_q     <= acc_d;
      k_q       <= k_d;
      duty_q    <= duty_d;
      period_q  <= period_d;
      stuck_q   <= stuck_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  // Next-state and datapath updates; duty is the largest k with k*P <= 10*H.
  always_comb begin
    state_d   = state_q;
    p_d       = p_q;
    target_d  = target_q;
    acc_d     = acc_q;
    k_d       = k_q;
    duty_d    = duty_q;
    period_d  = period_q;
    stuck_d   = stuck_q;
    valid_d   = 1'b0;
    dropped_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (rise) begin
          stuck_d = 1'b0;
          state_d = StMeasure;
        end
      end
      StMeasure: begin
        if (rise) begin
          p_d      = pcnt;
          // 10*H as 8*H + 2*H
          target_d = {1'b0, hcnt, 3'b000} + {3'b000, hcnt, 1'b0};
          acc_d    = 12'd0;
          k_d      = 4'd0;
          state_d  = StCalc;
        end
      end
      StCalc: begin
        if (rise) dropped_d = 1'b1;
        if ((k_q < 4'd10) && (acc_sum <= target_q)) begin
          acc_d = acc_sum;
          k_d   = k_q + 4'd1;
        end else begin
          duty_d   = k_q;
          period_d = p_q;
          valid_d  = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        if (rise) dropped_d = 1'b1;
        state_d = StMeasure;
      end
      default: state_d = StIdle;
    endcase

    if (timeout) begin
      stuck_d = 1'b1;
      duty_d  = level ? 4'd10 : 4'd0;
      valid_d = 1'b1;
      state_d = StIdle;
    end
  end

  assign bus.duty       = duty_q;
  assign bus.duty_valid = valid_q;
  assign bus.period     = period_q;
  assign bus.stuck      = stuck_q;
  assign bus.dropped    = dropped_q;
  assign bus.busy       = (state_q == StCalc) || (state_q == StDone);

endmodule
